// File: rtl/data_sender.sv
// data_sender: source side of a req/ack CDC handshake.
//   clka      : source-domain clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : producer word valid        in_data : producer word
//   in_ready  : block can take a word this cycle
//   data_req  : registered request to the receiver
//   data      : registered word, stable while data_req is high
//   data_ack  : receiver ack pulse, asynchronous to clka
//   tx_done   : one-cycle pulse when a word is acknowledged
//   tx_err    : one-cycle pulse when a word times out and is dropped
module data_sender #(
  parameter int N          = 4,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic         clka,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         data_req,
  output logic [N-1:0] data,
  input  logic         data_ack,
  output logic         tx_done,
  output logic         tx_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
  state_t        state_q, state_d;
  logic          ack_s1_q, ack_s2_q, ack_s3_q, ack_rise;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [7:0]    gap_q, gap_d;
  logic [N-1:0]  data_q, data_d;
  logic          req_q, req_d, done_q, done_d, err_q, err_d;
  assign ack_rise = ack_s2_q & ~ack_s3_q;
  assign in_ready = (state_q == IDLE);
  assign data_req = req_q;
  assign data     = data_q;
  assign tx_done  = done_q;
  assign tx_err   = err_q;
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        data_d  = in_data;
        req_d   = 1'b1;
        cnt_d   = '0;
        state_d = REQ;
      end
      REQ: begin
        cnt_d = (cnt_q == TW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
        // an ack arriving on the last timeout cycle still counts as delivered
        if (ack_rise || cnt_q == TW'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          done_d  = ack_rise;
          err_d   = ~ack_rise;
          gap_d   = 8'(GAP_CYCLES - 1);
          state_d = GAP;
        end
      end
      GAP: if (gap_q == 8'd0) state_d = IDLE; else gap_d = gap_q - 8'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
      ack_s3_q <= 1'b0;
      cnt_q    <= '0;
      gap_q    <= '0;
      data_q   <= '0;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_s1_q <= data_ack;
      ack_s2_q <= ack_s1_q;
      ack_s3_q <= ack_s2_q;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      data_q   <= data_d;
      req_q    <= req_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: doc/data_sender.md
# data_sender

Source-side half of the req/ack clock-domain-crossing pair. Runs in the `clka` domain. Takes N-bit words from a local valid/ready producer, holds each word stable on `data` while raising `data_req`, and waits for the single-cycle `data_ack` pulse from the `clkb`-domain receiver. It then returns `data_req` low for a guaranteed gap so that the receiver sees a fresh rising edge for the next word.

## Interface
- `N`, default 4: data word width.
- `GAP_CYCLES`, default 4: minimum `clka` cycles `data_req` stays low between words; legal range 1..255.
- `TIMEOUT`, default 32: `clka` cycles spent in REQ without a detected ack before the word is abandoned; legal range 4..65535.
- `clka`, input, 1: source-domain clock.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: producer has a word on `in_data`.
- `in_data`, input, N: word to send.
- `in_ready`, output, 1: block accepts a word this cycle.
- `data_req`, output, N/A width 1: request to the receiver; registered, glitch-free.
- `data`, output, N: word to the receiver; registered; stable while `data_req` = 1.
- `data_ack`, input, 1: receiver ack; asynchronous to `clka`.
- `tx_done`, output, 1: one-cycle pulse when a word is acknowledged.
- `tx_err`, output, 1: one-cycle pulse when a word times out.

## Operation
- Ack path:
  - `data_ack` passes through a 2-flop synchronizer (`ack_s1`, `ack_s2`) and then a third flop `ack_s3`.
  - `ack_rise` = `ack_s2` & ~`ack_s3`.
  - All ack-path flops reset to 0.
- FSM states: IDLE, REQ, GAP. Reset state is IDLE.
- `in_ready` = (state == IDLE). It is decoded directly from the state register, with no dependence on `in_valid`.
- IDLE:
  - On `in_valid` & `in_ready`: register `in_data` into `data`, set `data_req` to 1, clear the timeout counter, go to REQ.
  - Otherwise hold. `data` keeps its last value.
- REQ:
  - Increment the timeout counter each cycle. Its width is clog2(TIMEOUT+1), and it saturates rather than wrapping.
  - On `ack_rise`: `data_req` goes to 0, `tx_done` pulses, load the gap counter with GAP_CYCLES-1, go to GAP.
  - Else, when the counter reaches TIMEOUT-1: `data_req` goes to 0, `tx_err` pulses, load the gap counter, go to GAP. The word is dropped and never retried.
  - `ack_rise` takes priority over timeout in the same cycle.
- GAP:
  - `data_req` stays 0. Decrement the gap counter each cycle.
  - When it reaches 0, go to IDLE.
  - A new `in_valid` is not accepted during GAP.
- `ack_rise` seen in IDLE or GAP (a late or spurious ack) is ignored: no state change, no pulse.
- `data` never changes while in REQ. It changes only on an accepted handshake.
- Reset (any time, including mid-REQ):
  - Outputs: `data_req` = 0, `data` = 0, `tx_done` = 0, `tx_err` = 0, `in_ready` = 1 (state IDLE).
  - All counters and sync flops are cleared.

## Timing
- Accept to request: `data_req` rises 1 cycle after the `in_valid` & `in_ready` edge, and `data` is valid in that same cycle.
- Ack to request drop: `data_ack` rising to `data_req` falling takes 3–4 `clka` edges (2 synchronizer stages + edge detect + registered output).
- Word period with an ideal ack: 1 (accept) + REQ dwell + GAP_CYCLES. Back-to-back throughput is therefore limited by the CDC round trip.
- System constraint: the `clka` period plus setup time must be less than one `clkb` period, so that the one-cycle `clkb` ack pulse is captured. GAP_CYCLES × Tclka must be at least 2 × Tclkb, so that the receiver's edge detector sees `data_req` low.
- `tx_done` and `tx_err` are registered. They assert in the same cycle that `data_req` falls and are never both 1.

## Test plan
- Single word, N=4, GAP_CYCLES=4:
  - Stimulus: `in_data`=4'hA with `in_valid`=1 for one cycle; `data_ack` is driven high for 1 cycle, 5 cycles after `data_req` rises.
  - Required: `in_ready` goes 0 the cycle after accept; `data`=4'hA and stays stable; `data_req` falls 3–4 cycles after the ack; `tx_done` pulses once; `in_ready` returns to 1 exactly 4 cycles after `data_req` falls.
- Back-to-back words:
  - Stimulus: 4'h3, 4'hC and 4'h5 presented with `in_valid` held high; a receiver model acks each.
  - Required: three accepts in order; `data_req` low for ≥4 cycles between requests; three `tx_done` pulses; `data` sequence 3, C, 5.
- Timeout, TIMEOUT=32:
  - Stimulus: `data_ack` held 0 after accepting 4'h7.
  - Required: `data_req` falls after 32 cycles in REQ; `tx_err` pulses once and `tx_done` stays 0; the block returns to IDLE after the gap.
- Spurious and late ack:
  - Stimulus: a `data_ack` pulse while in IDLE, and another during GAP.
  - Required: no state change; `tx_done`=0; `data_req` stays 0.
- Reset mid-REQ:
  - Stimulus: assert `rst_n`=0 asynchronously while `data_req`=1 and `data`=4'hF.
  - Required: `data_req`=0, `data`=0 and `in_ready`=1 immediately; after release, a new word 4'h1 is accepted normally.
- Ack coincident with timeout:
  - Stimulus: `ack_rise` lands on counter value TIMEOUT-1.
  - Required: `tx_done` pulses and `tx_err` stays 0.
